// File: rtl/bp_pkg.sv
// Branch predictor shared types: counter encoding, default sizes,
// and the 2-bit saturating counter update function.
package bp_pkg;

  localparam int BP_ENTRIES = 16;
  localparam int BP_XLEN    = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  function automatic ctr_t ctr_next(
    input ctr_t c,
    input logic taken
  );
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != ST) n = ctr_t'(c + 2'b01);
    end else begin
      if (c != SNT) n = ctr_t'(c - 2'b01);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter predictor. Zero-latency lookup of
// fetch_pc_i; resolve_* updates the table on the next rising edge.
// Ports: clk_i, rst_i (sync, active-high), fetch_pc_i -> predict_taken_o,
// predict_target_o; resolve_* inputs -> mispredict_o (registered pulse).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int XLEN    = BP_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            predict_taken_o,
  output logic [XLEN-1:0] predict_target_o,
  input  logic            resolve_valid_i,
  input  logic [XLEN-1:0] resolve_pc_i,
  input  logic            resolve_taken_i,
  input  logic [XLEN-1:0] resolve_target_i,
  input  logic            resolve_pred_taken_i,
  output logic            mispredict_o
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  logic            valid_q [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0] tgt_q   [ENTRIES];
  ctr_t            ctr_q   [ENTRIES];
  logic            mis_q;

  logic [IDXW-1:0] f_idx;
  logic [TAGW-1:0] f_tag;
  logic            f_hit;
  logic [IDXW-1:0] r_idx;
  logic [TAGW-1:0] r_tag;
  logic            r_hit;
  logic            unused_pc_bits;

  assign f_idx = fetch_pc_i[IDXW+1:2];
  assign f_tag = fetch_pc_i[XLEN-1:IDXW+2];
  assign r_idx = resolve_pc_i[IDXW+1:2];
  assign r_tag = resolve_pc_i[XLEN-1:IDXW+2];

  // Instructions are word aligned; the low PC bits carry no information.
  assign unused_pc_bits = ^{fetch_pc_i[1:0], resolve_pc_i[1:0]};

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  // Lookup reads registered state only, so a same-cycle resolve is
  // seen from the following cycle.
  assign predict_taken_o  = f_hit && ctr_q[f_idx][1];
  assign predict_target_o = predict_taken_o ? tgt_q[f_idx]
                                            : fetch_pc_i + XLEN'(4);
  assign mispredict_o     = mis_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
      mis_q <= 1'b0;
    end else begin
      mis_q <= resolve_valid_i &&
               (resolve_taken_i != resolve_pred_taken_i);
      if (resolve_valid_i) begin
        if (r_hit) begin
          ctr_q[r_idx] <= ctr_next(ctr_q[r_idx], resolve_taken_i);
          if (resolve_taken_i) tgt_q[r_idx] <= resolve_target_i;
        end else if (resolve_taken_i) begin
          // Taken miss replaces whatever occupied the slot.
          valid_q[r_idx] <= 1'b1;
          tag_q[r_idx]   <= r_tag;
          tgt_q[r_idx]   <= resolve_target_i;
          ctr_q[r_idx]   <= WT;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed steps push expected
// outputs; a negedge monitor pops and compares.
module tb_branch_predictor;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] fetch_pc;
  logic            p_taken;
  logic [XLEN-1:0] p_target;
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic            r_taken;
  logic [XLEN-1:0] r_target;
  logic            r_pred;
  logic            mis;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
    logic            mis;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  done    = 1'b0;

  branch_predictor dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .fetch_pc_i          (fetch_pc),
    .predict_taken_o     (p_taken),
    .predict_target_o    (p_target),
    .resolve_valid_i     (r_valid),
    .resolve_pc_i        (r_pc),
    .resolve_taken_i     (r_taken),
    .resolve_target_i    (r_target),
    .resolve_pred_taken_i(r_pred),
    .mispredict_o        (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests += 3;
      if (p_taken !== e.taken) begin
        n_fail++;
        $display("FAIL %s taken: got %0b want %0b", nm, p_taken, e.taken);
      end
      if (p_target !== e.target) begin
        n_fail++;
        $display("FAIL %s target: got %h want %h", nm, p_target, e.target);
      end
      if (mis !== e.mis) begin
        n_fail++;
        $display("FAIL %s mispredict: got %0b want %0b", nm, mis, e.mis);
      end
    end
  end

  // One cycle: drive fetch/resolve just after the edge, then queue what
  // the outputs must show before the next edge.
  task automatic step(
    input string           nm,
    input logic [XLEN-1:0] fpc,
    input logic            rv,
    input logic [XLEN-1:0] rpc,
    input logic            rt,
    input logic [XLEN-1:0] rtg,
    input logic            rp,
    input logic            et,
    input logic [XLEN-1:0] etg,
    input logic            em
  );
    exp_t e;
    @(posedge clk);
    #1;
    fetch_pc = fpc;
    r_valid  = rv;
    r_pc     = rpc;
    r_taken  = rt;
    r_target = rtg;
    r_pred   = rp;
    e.taken  = et;
    e.target = etg;
    e.mis    = em;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic look(
    input string           nm,
    input logic [XLEN-1:0] fpc,
    input logic            et,
    input logic [XLEN-1:0] etg,
    input logic            em
  );
    step(nm, fpc, 1'b0, '0, 1'b0, '0, 1'b0, et, etg, em);
  endtask

  initial begin
    rst      = 1'b1;
    fetch_pc = '0;
    r_valid  = 1'b0;
    r_pc     = '0;
    r_taken  = 1'b0;
    r_target = '0;
    r_pred   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    look("reset_pred", 32'h100, 0, 32'h104, 0);
    look("wrap", 32'hFFFF_FFFC, 0, 32'h0, 0);
    step("same_cycle_old", 32'h100, 1, 32'h100, 1, 32'h80, 0,
         0, 32'h104, 0);
    look("alloc_new", 32'h100, 1, 32'h80, 1);
    look("mis_one_cycle", 32'h100, 1, 32'h80, 0);
    step("wt_to_wnt", 32'h100, 1, 32'h100, 0, 32'h0, 1,
         1, 32'h80, 0);
    step("wnt_to_snt", 32'h100, 1, 32'h100, 0, 32'h0, 0,
         0, 32'h104, 1);
    look("snt", 32'h100, 0, 32'h104, 0);
    step("snt_to_wnt", 32'h100, 1, 32'h100, 1, 32'h80, 0,
         0, 32'h104, 0);
    step("wnt_to_wt", 32'h100, 1, 32'h100, 1, 32'h80, 0,
         0, 32'h104, 1);
    step("wt_to_st", 32'h100, 1, 32'h100, 1, 32'h90, 1,
         1, 32'h80, 1);
    step("st_hold", 32'h100, 1, 32'h100, 1, 32'h90, 1,
         1, 32'h90, 0);
    step("st_to_wt", 32'h100, 1, 32'h100, 0, 32'h0, 1,
         1, 32'h90, 0);
    look("wt_after_sat", 32'h100, 1, 32'h90, 1);
    step("wt_to_wnt2", 32'h100, 1, 32'h100, 0, 32'h0, 1,
         1, 32'h90, 0);
    look("wnt2", 32'h100, 0, 32'h104, 1);
    step("alias_alloc", 32'h140, 1, 32'h140, 1, 32'h200, 0,
         0, 32'h144, 0);
    look("alias_evict", 32'h100, 0, 32'h104, 1);
    look("alias_new", 32'h140, 1, 32'h200, 0);
    step("miss_nt", 32'h140, 1, 32'h180, 0, 32'h0, 0,
         1, 32'h200, 0);
    look("miss_nt_keep", 32'h140, 1, 32'h200, 0);
    step("invalid_res", 32'h140, 0, 32'h140, 0, 32'h0, 1,
         1, 32'h200, 0);
    look("invalid_keep", 32'h140, 1, 32'h200, 0);
    step("idx1_alloc", 32'h104, 1, 32'h104, 1, 32'h40, 0,
         0, 32'h108, 0);
    look("idx1_hit", 32'h104, 1, 32'h40, 1);
    step("idx0_intact", 32'h140, 1, 32'h104, 0, 32'h0, 1,
         1, 32'h200, 0);

    // Reset arrives together with a taken resolve and a pending pulse.
    @(posedge clk);
    #1 rst = 1'b1;
    begin
      exp_t e;
      fetch_pc = 32'h140;
      r_valid  = 1'b1;
      r_pc     = 32'h100;
      r_taken  = 1'b1;
      r_target = 32'h80;
      r_pred   = 1'b0;
      e.taken  = 1'b1;
      e.target = 32'h200;
      e.mis    = 1'b1;
      exp_q.push_back(e);
      name_q.push_back("pre_reset");
    end
    @(posedge clk);
    #1 rst = 1'b0;
    r_valid  = 1'b0;
    fetch_pc = 32'h100;
    begin
      exp_t e;
      e.taken  = 1'b0;
      e.target = 32'h104;
      e.mis    = 1'b0;
      exp_q.push_back(e);
      name_q.push_back("rst_discard_res");
    end
    look("rst_clear_alias", 32'h140, 0, 32'h144, 0);
    look("rst_clear_idx1", 32'h104, 0, 32'h108, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES SHALL default to 16; it is the table depth, a power of two, 4..256.
REQ-002 Parameter XLEN SHALL default to 32; it is the PC and target width.
REQ-003 clk_i SHALL be an input of width 1; it is the single clock, and all state updates on its rising edge.
REQ-004 rst_i SHALL be an input of width 1; it is the synchronous, active-high reset.
REQ-005 fetch_pc_i SHALL be an input of width XLEN; it is the PC being fetched this cycle.
REQ-006 predict_taken_o SHALL be an output of width 1; it is the predicted direction for fetch_pc_i.
REQ-007 predict_target_o SHALL be an output of width XLEN; it is the predicted next PC for fetch_pc_i.
REQ-008 resolve_valid_i SHALL be an input of width 1; it is a one-cycle pulse meaning a conditional branch has resolved.
REQ-009 resolve_pc_i SHALL be an input of width XLEN; it is the PC of the resolved branch.
REQ-010 resolve_taken_i SHALL be an input of width 1; it is the actual direction, i.e. the branch unit's branch_taken_o.
REQ-011 resolve_target_i SHALL be an input of width XLEN; it is the computed taken target.
REQ-012 resolve_pred_taken_i SHALL be an input of width 1; it is the direction predicted for this branch at fetch time.
REQ-013 mispredict_o SHALL be an output of width 1; it is a registered one-cycle flag meaning the last resolve was mispredicted.

Function
REQ-014 Index SHALL be pc[IDXW+1:2], where IDXW = log2(ENTRIES); tag SHALL be pc[XLEN-1:IDXW+2].
REQ-015 Each entry SHALL hold valid (1 bit), tag, target (XLEN bits) and a 2-bit saturating counter.
REQ-016 Counter encodings SHALL be SNT=00, WNT=01, WT=10, ST=11.
REQ-017 Lookup SHALL be combinational and zero-latency: hit = valid && tag match at the fetch_pc_i index.
REQ-018 predict_taken_o SHALL equal hit && counter[1].
REQ-019 predict_target_o SHALL be the entry target when predict_taken_o is 1, else fetch_pc_i + 4, modulo 2^XLEN.
REQ-020 A resolve hit SHALL update the counter on the next rising edge: taken increments, saturating at ST; not-taken decrements, saturating at SNT.
REQ-021 A resolve hit with resolve_taken_i=1 SHALL also overwrite the entry target with resolve_target_i.
REQ-022 A resolve miss with resolve_taken_i=1 SHALL allocate the entry, replacing any previous occupant: valid=1, new tag, target=resolve_target_i, counter=WT.
REQ-023 A resolve miss with resolve_taken_i=0 SHALL leave the table unchanged.
REQ-024 mispredict_o SHALL be registered, high for exactly the cycle after a resolve where resolve_valid_i && (resolve_taken_i != resolve_pred_taken_i), and low otherwise.
REQ-025 With a resolve and a lookup at the same index in one cycle, the lookup SHALL return pre-update state (no bypass); the update SHALL be visible from the following cycle.
REQ-026 At most one resolve per cycle SHALL be accepted; resolve inputs SHALL be ignored when resolve_valid_i=0.

Reset
REQ-027 While rst_i=1 at a rising edge, every entry SHALL reset to valid=0 and counter=WNT; tag and target are don't-care.
REQ-028 While rst_i=1, mispredict_o SHALL reset to 0.
REQ-029 Reset SHALL take priority over a simultaneous resolve, which is discarded.
REQ-030 After reset, predict_taken_o SHALL be 0 and predict_target_o SHALL be fetch_pc_i + 4 for every PC.
REQ-031 Reset asserted mid-operation SHALL discard all learned state within one cycle.

Structure
REQ-032 A shared package bp_pkg SHALL hold the counter enum, the ENTRIES/XLEN defaults and a pure function for the saturating counter update.
REQ-033 No sub-module SHALL be used; tables are flop arrays inside branch_predictor.

Verification
REQ-034 After reset, fetch_pc_i=0x100 SHALL give predict_taken_o=0 and predict_target_o=0x104.
REQ-035 A taken resolve of pc 0x100 to 0x80 SHALL, next cycle, make fetch 0x100 give taken=1 and target=0x80.
REQ-036 Two not-taken resolves of 0x100 (WT->WNT->SNT) SHALL make fetch 0x100 give taken=0; three further taken resolves SHALL reach ST, and one more SHALL hold ST (saturation).
REQ-037 With ENTRIES=16, 0x100 and 0x140 alias to index 0; a taken 0x140 resolve SHALL evict 0x100, so fetch 0x100 gives taken=0 and target=0x104.
REQ-038 A resolve with taken=1, pred_taken=0 SHALL raise mispredict_o for exactly one cycle; a resolve with taken=pred_taken SHALL keep it 0.
REQ-039 A same-cycle resolve (0x100, taken, 0x80) and fetch 0x100 SHALL show the old prediction, and the new one the next cycle; a resolve coinciding with rst_i=1 SHALL leave the table empty.
